// File: rtl/devc_pkg.sv
// Shared types and default sizing for the word-sink slice.
package devc_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/devc_fwft_fifo.sv
// First-word-fall-through FIFO with a registered head word, occupancy and flags.
module devc_fwft_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clkB,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdPtrInc;
    logic [LVL_W-1:0] levelNext;
    logic [WIDTH-1:0] headNext;
    logic             pop;
    logic             wrOk;

    // A pop needs data; a write needs room, which a same-cycle pop provides.
    always_comb begin
        pop       = rd_en & valid;
        wrOk      = wr_en & (~full | pop);
        rdPtrInc  = rdPtr + PTR_W'(1);
        levelNext = level;
        headNext  = dout;
        if (wrOk && !pop) begin
            levelNext = level + LVL_W'(1);
        end else if (pop && !wrOk) begin
            levelNext = level - LVL_W'(1);
        end
        // Head moves to the next stored entry, or takes the incoming word when
        // it becomes the only one; an emptied FIFO keeps the last head.
        if (pop && (level > LVL_W'(1))) begin
            headNext = mem[rdPtrInc];
        end else if (wrOk && ((level == LVL_W'(0)) || pop)) begin
            headNext = din;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clkB) begin
        if (wrOk) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers, occupancy, head word and status flags.
    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            dout  <= '0;
            valid <= 1'b0;
            full  <= 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtrInc;
            end
            level <= levelNext;
            dout  <= headNext;
            valid <= (levelNext != LVL_W'(0));
            full  <= (levelNext == LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/devc_word_sink.sv
// Captures upstream words via the readyB/acceptedB -> acceptedC handshake,
// buffers them in a FWFT FIFO and drains them over valid/ready.
module devc_word_sink
    import devc_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                     clkB,
    input  logic                     rst,
    input  logic [63:0]              sharedBus64,
    input  logic                     readyB,
    input  logic                     acceptedB,
    output logic                     acceptedC,
    output logic [63:0]              dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         word_count,
    output logic                     proto_err
);

    state_t state;
    state_t stateNext;
    logic   offer;
    logic   pop;
    logic   wrEn;
    logic   errSet;
    logic   fifoFull;
    word_t  headWord;

    // Handshake FSM: capture once per upstream word, then wait for readyB to drop.
    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        errSet    = 1'b0;
        offer     = readyB & acceptedB;
        pop       = dout_valid & dout_ready;
        case (state)
            IDLE: begin
                if (offer && (!fifoFull || pop)) begin
                    wrEn      = 1'b1;
                    stateNext = ACK;
                end
                if (acceptedB && !readyB) begin
                    errSet = 1'b1;
                end
            end
            ACK: begin
                stateNext = WAIT_LOW;
                if (!readyB) begin
                    errSet = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!readyB) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Acknowledge is high exactly while the FSM sits in ACK.
    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            acceptedC <= 1'b0;
        end else begin
            acceptedC <= (stateNext == ACK);
        end
    end

    // Captured-word counter, wraps naturally.
    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if (wrEn) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (errSet) begin
            proto_err <= 1'b1;
        end
    end

    devc_fwft_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) uFifo (
        .clkB  (clkB),
        .rst   (rst),
        .wr_en (wrEn),
        .din   (sharedBus64),
        .rd_en (dout_ready),
        .dout  (headWord),
        .valid (dout_valid),
        .level (fifo_level),
        .full  (fifoFull)
    );

    assign dout = headWord;

endmodule

// File: tb/tb_devc_word_sink.sv
// Scoreboard bench for devc_word_sink: the upstream driver queues each word it
// issues, the monitor checks every word the local consumer takes.
module tb_devc_word_sink;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic               clkB = 1'b0;
    logic               rst = 1'b0;
    logic [63:0]        sharedBus64 = '0;
    logic               readyB = 1'b0;
    logic               acceptedB = 1'b0;
    logic               acceptedC;
    logic [63:0]        dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic [LVL_W-1:0]   fifo_level;
    logic [CNT_W-1:0]   word_count;
    logic               proto_err;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          base = 0;
    bit          randomMode = 1'b0;
    logic [63:0] expQ [$];
    logic [63:0] w5;
    logic [63:0] w6;
    logic [63:0] wr;

    devc_word_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clkB        (clkB),
        .rst         (rst),
        .sharedBus64 (sharedBus64),
        .readyB      (readyB),
        .acceptedB   (acceptedB),
        .acceptedC   (acceptedC),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .fifo_level  (fifo_level),
        .word_count  (word_count),
        .proto_err   (proto_err)
    );

    always #5 clkB = ~clkB;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Acknowledge cycles seen by the upstream side.
    always @(negedge clkB) begin
        if (rst && acceptedC) pulses++;
    end

    // Monitor: every word the consumer takes must be the oldest one issued.
    always @(negedge clkB) begin
        if (rst && dout_valid && dout_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dout_extra actual=%h required=none", dout);
            end else begin
                chk("dout_order", dout, expQ.pop_front());
            end
        end
    end

    // Random consumer backpressure.
    always @(posedge clkB) begin
        #1;
        if (randomMode) dout_ready = 1'($urandom_range(0, 1));
    end

    task automatic waitAck(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clkB);
            if (acceptedC) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s actual=no_ack required=ack", name);
        end
    endtask

    task automatic dropUp();
        @(posedge clkB); #1;
        readyB = 1'b0;
        acceptedB = 1'b0;
        sharedBus64 = {$urandom, $urandom};
    endtask

    task automatic sendWord(input logic [63:0] w, input int hold);
        @(posedge clkB); #1;
        sharedBus64 = w;
        readyB = 1'b1;
        acceptedB = 1'b1;
        expQ.push_back(w);
        waitAck("ack_timeout");
        repeat (hold) @(posedge clkB);
        dropUp();
    endtask

    task automatic drain();
        @(posedge clkB); #1;
        dout_ready = 1'b1;
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clkB);
        chk("drain_empty", 64'(expQ.size()), 64'd0);
        @(posedge clkB); #1;
        dout_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clkB);
        @(negedge clkB);
        chk("rst_acceptedC", 64'(acceptedC), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        rst = 1'b1;

        // Single word with readyB held 10 cycles past the acknowledge.
        base = pulses;
        sendWord(64'h0102030405060708, 10);
        @(negedge clkB);
        chk("single_pulses", 64'(pulses - base), 64'd1);
        chk("single_dout", dout, 64'h0102030405060708);
        chk("single_valid", 64'(dout_valid), 64'd1);
        chk("single_level", 64'(fifo_level), 64'd1);
        chk("single_count", 64'(word_count), 64'd1);
        drain();

        // Backpressure: four words fill the FIFO, the fifth waits for a pop.
        base = pulses;
        for (int i = 0; i < 4; i++) sendWord(64'hA0A0_0000_0000_0000 | 64'(i), 0);
        @(negedge clkB);
        chk("bp_level_full", 64'(fifo_level), 64'd4);
        chk("bp_pulses", 64'(pulses - base), 64'd4);
        w5 = 64'hB5B5_B5B5_5B5B_5B5B;
        @(posedge clkB); #1;
        sharedBus64 = w5;
        readyB = 1'b1;
        acceptedB = 1'b1;
        expQ.push_back(w5);
        repeat (5) @(posedge clkB);
        @(negedge clkB);
        chk("bp_no_ack", 64'(pulses - base), 64'd4);
        @(posedge clkB); #1;
        dout_ready = 1'b1;
        @(posedge clkB); #1;
        dout_ready = 1'b0;
        @(negedge clkB);
        chk("bp_ack_after_pop", 64'(acceptedC), 64'd1);
        chk("bp_level_refill", 64'(fifo_level), 64'd4);
        dropUp();

        // Write and pop in the same cycle at full.
        w6 = 64'hC6C6_0000_1111_2222;
        @(posedge clkB); #1;
        sharedBus64 = w6;
        readyB = 1'b1;
        acceptedB = 1'b1;
        dout_ready = 1'b1;
        expQ.push_back(w6);
        @(posedge clkB); #1;
        dout_ready = 1'b0;
        @(negedge clkB);
        chk("full_pop_ack", 64'(acceptedC), 64'd1);
        chk("full_pop_level", 64'(fifo_level), 64'd4);
        dropUp();
        drain();
        @(negedge clkB);
        chk("drained_level", 64'(fifo_level), 64'd0);
        chk("drained_valid", 64'(dout_valid), 64'd0);
        chk("drained_dout_hold", dout, w6);

        // readyB withdrawn during ACK.
        @(posedge clkB); #1;
        sharedBus64 = 64'hDEAD_0000_0000_0001;
        readyB = 1'b1;
        acceptedB = 1'b1;
        expQ.push_back(sharedBus64);
        @(posedge clkB); #1;
        readyB = 1'b0;
        acceptedB = 1'b0;
        repeat (2) @(negedge clkB);
        chk("perr_set", 64'(proto_err), 64'd1);
        sendWord(64'h1111_2222_3333_4444, 1);
        @(negedge clkB);
        chk("perr_sticky", 64'(proto_err), 64'd1);

        // Asynchronous reset while acknowledging; held word is re-captured.
        wr = 64'h5555_6666_7777_8888;
        @(posedge clkB); #1;
        sharedBus64 = wr;
        readyB = 1'b1;
        acceptedB = 1'b1;
        @(posedge clkB); #1;
        chk("pre_rst_ack", 64'(acceptedC), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(acceptedC), 64'd0);
        chk("mid_rst_perr", 64'(proto_err), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        expQ.delete();
        @(negedge clkB);
        expQ.push_back(wr);
        rst = 1'b1;
        waitAck("recapture_ack");
        dropUp();
        @(negedge clkB);
        chk("recapture_count", 64'(word_count), 64'd1);
        chk("recapture_level", 64'(fifo_level), 64'd1);

        // acceptedB without readyB while idle.
        @(posedge clkB); #1;
        acceptedB = 1'b1;
        @(posedge clkB); #1;
        acceptedB = 1'b0;
        @(negedge clkB);
        chk("idle_perr", 64'(proto_err), 64'd1);
        drain();

        // Fresh reset, then 17 random words under random backpressure.
        @(negedge clkB);
        rst = 1'b0;
        repeat (2) @(negedge clkB);
        expQ.delete();
        rst = 1'b1;
        base = pulses;
        randomMode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clkB);
            sendWord({$urandom, $urandom}, int'($urandom_range(0, 3)));
        end
        randomMode = 1'b0;
        drain();
        @(negedge clkB);
        chk("rand_pulses", 64'(pulses - base), 64'd17);
        chk("rand_count_wrap", 64'(word_count), 64'(17 % (1 << CNT_W)));
        chk("rand_level", 64'(fifo_level), 64'd0);
        chk("rand_perr", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
